// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back select and the D-cache wait FSM.
// Define INSTRET_CNT_EN to build the 64-bit retired-instruction counter; otherwise instret is 0.
module mem_wb_stage #(
  parameter int BIT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [BIT_W-1:0] alu_result_in,
  input  logic [4:0]       rd_in,
  input  logic             memrd_in,
  input  logic             memwr_in,
  input  logic             mem2reg_in,
  input  logic             regwr_in,
  input  logic [BIT_W-1:0] dcache_rdata,
  input  logic             dcache_stall,
  input  logic             stall_in,
  output logic             stall_req,
  output logic             dmem_hold,
  output logic [4:0]       wb_rd,
  output logic [BIT_W-1:0] wb_data,
  output logic             wb_regwr,
  output logic [63:0]      instret
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [BIT_W-1:0] cap_q;
  logic [4:0]       wb_rd_q;
  logic [BIT_W-1:0] wb_data_q;
  logic             wb_regwr_q;

  logic             acc;
  logic             pending;
  logic             complete;
  logic             stall_req_s;
  logic             adv;
  logic [BIT_W-1:0] load_data;

  assign acc         = valid_in & (memrd_in | memwr_in);
  // An access is outstanding while waiting, or when a new one is presented in IDLE.
  assign pending     = (state_q == ST_WAIT) | ((state_q == ST_IDLE) & acc);
  assign stall_req_s = rst_n & pending & dcache_stall;
  assign complete    = pending & ~dcache_stall;
  assign adv         = ~stall_in & ~stall_req_s;
  assign load_data   = (state_q == ST_DONE) ? cap_q : dcache_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cap_q   <= {BIT_W{1'b0}};
    end else begin
      if (complete) begin
        cap_q <= dcache_rdata;
      end
      case (state_q)
        ST_IDLE: begin
          if (acc & dcache_stall) begin
            state_q <= ST_WAIT;
          end else if (acc & stall_in) begin
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!dcache_stall) begin
            state_q <= stall_in ? ST_DONE : ST_IDLE;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_DONE: begin
          if (!stall_in) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A frozen cycle injects a bubble so each instruction writes the register file once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_rd_q    <= 5'd0;
      wb_data_q  <= {BIT_W{1'b0}};
      wb_regwr_q <= 1'b0;
    end else if (adv) begin
      wb_rd_q    <= rd_in;
      wb_data_q  <= mem2reg_in ? load_data : alu_result_in;
      wb_regwr_q <= valid_in & regwr_in & (rd_in != 5'd0);
    end else begin
      wb_regwr_q <= 1'b0;
    end
  end

`ifdef INSTRET_CNT_EN
  logic [63:0] instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= 64'd0;
    end else if (adv & valid_in) begin
      instret_q <= instret_q + 64'd1;
    end else begin
      instret_q <= instret_q;
    end
  end

  assign instret = instret_q;
`else
  assign instret = 64'd0;
`endif

  assign stall_req = stall_req_s;
  assign dmem_hold = (state_q == ST_DONE);
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign wb_regwr  = wb_regwr_q;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus write-back select for the 5-stage RISC-V core.
- Sits directly downstream of the MEM stage. Consumes its ALU result, destination register and control bits, plus the D-cache read data/stall.
- Owns the data-access wait FSM:
  - raises a stall request while the D-cache is busy;
  - captures load data the cycle the cache completes;
  - holds that data if the pipeline is frozen by another cause.
- Drives the register-file write port.

Parameters:
BIT_W, 32, datapath width (ALU result, load data, write-back data)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
valid_in  input  1  MEM stage holds a real instruction (0 = bubble)
alu_result_in  input  BIT_W  ALU result / store address from MEM stage
rd_in  input  5  destination register
memrd_in  input  1  instruction is a load
memwr_in  input  1  instruction is a store
mem2reg_in  input  1  write-back selects load data (1) or ALU result (0)
regwr_in  input  1  instruction writes rd
dcache_rdata  input  BIT_W  D-cache read data, valid only in the cycle dcache_stall is low
dcache_stall  input  1  D-cache busy with the current access
stall_in  input  1  stall from other pipeline sources (I-cache, hazard unit)
stall_req  output  1  this block requests a pipeline freeze
dmem_hold  output  1  access already completed; MEM stage must not re-issue the cache request
wb_rd  output  5  register-file write address
wb_data  output  BIT_W  register-file write data
wb_regwr  output  1  register-file write enable
instret  output  64  retired-instruction count (only with INSTRET_CNT_EN)

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE immediately.
  - stall_req=0, dmem_hold=0, wb_rd=0, wb_data=0, wb_regwr=0, instret=0, capture register=0.
  - Reset asserted during WAIT abandons the access. No write-back occurs.
- Definitions:
  - acc = valid_in & (memrd_in | memwr_in).
  - adv = ~stall_in & ~stall_req.
- FSM states: IDLE, WAIT, DONE.
  - IDLE:
    - acc & dcache_stall -> WAIT; stall_req=1 combinationally in this cycle.
    - acc & ~dcache_stall (1-cycle hit) -> capture dcache_rdata. If stall_in=1 -> DONE, else stay IDLE and advance.
    - No access -> stay IDLE.
  - WAIT:
    - stall_req=1 while dcache_stall=1.
    - First cycle with dcache_stall=0: stall_req=0 and capture dcache_rdata. If stall_in=0 -> advance, go IDLE; else -> DONE.
  - DONE:
    - stall_req=0, dmem_hold=1.
    - Load data comes from the capture register; dcache_rdata is ignored.
    - When stall_in=0 -> advance, go IDLE.
- Load data source: the capture register in DONE; dcache_rdata combinationally in the completing cycle of IDLE/WAIT.
- Register update when adv=1:
  - wb_rd <= rd_in.
  - wb_data <= (mem2reg_in ? load data : alu_result_in).
  - wb_regwr <= valid_in & regwr_in & (rd_in != 0).
  - Write-back latency is exactly one cycle after the advancing edge.
- Register update when adv=0:
  - wb_rd and wb_data hold their values.
  - wb_regwr <= 0 (a bubble is injected), so every instruction writes the register file exactly once.
- Stores: take the same FSM path; the capture register is don't-care. wb_regwr follows regwr_in (normally 0).
- Simultaneous stall_in=1 and dcache completion: data is captured and the FSM goes to DONE. Data must not be lost when the cache drops rdata on the next cycle.
- Consecutive accesses: IDLE -> WAIT -> IDLE -> WAIT with no dead cycle between them.
- Bubbles (valid_in=0): never start an access and never write.

Optional Feature:
- Macro: INSTRET_CNT_EN.
- Defined:
  - instret is a 64-bit counter, incremented on every edge where adv=1 & valid_in=1.
  - Stores and bubbles-by-stall are counted correctly: stalled cycles never increment.
  - Wraps from 2^64-1 to 0.
- Undefined:
  - instret is tied to 0 and the counter logic is removed.
  - The port remains so that the top-level wiring is unchanged.

Test Plan:
- ALU op, valid_in=1, regwr_in=1, rd_in=5, alu_result_in=0x0000_1234, no stalls -> next cycle wb_regwr=1, wb_rd=5, wb_data=0x1234; following cycle wb_regwr=0 if the input is a bubble.
- Load with rd_in=7, dcache_stall high 3 cycles then low with dcache_rdata=0xDEAD_BEEF -> stall_req=1 for exactly 3 cycles; one cycle after completion wb_data=0xDEADBEEF, wb_regwr=1 exactly once.
- Load completes (dcache_stall falls, rdata=0xCAFE_0001) while stall_in=1 for 2 more cycles, rdata changed to 0 afterwards -> dmem_hold=1 for 2 cycles, stall_req=0; after release wb_data=0xCAFE0001.
- regwr_in=1, rd_in=0, alu_result_in=0xFFFF_FFFF -> wb_regwr stays 0.
- rst_n pulsed low mid-WAIT -> all outputs 0 asynchronously, FSM in IDLE, no write-back after reset release.
- With INSTRET_CNT_EN: 10 valid instructions including one 4-cycle D-cache miss and 3 bubbles -> instret=10.
